// File: rtl/rob_commit.sv
// Reorder buffer and in-order commit stage.
// Out-of-order ALU/MUL completions are captured by ticket. One entry retires per cycle
// in program order. An excepting entry flushes the whole buffer instead of writing back.
module rob_commit #(
    parameter int unsigned ROB_ENTRIES = 8,
    parameter int unsigned ROB_IDX_W   = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_W       = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic                 alu_wb_valid,
    input  logic [ROB_IDX_W-1:0] alu_wb_id,
    input  logic                 alu_wb_we,
    input  logic [REG_W-1:0]     alu_wb_rd,
    input  logic [DATA_W-1:0]    alu_wb_data,
    input  logic [DATA_W-1:0]    alu_wb_pc,
    input  logic                 alu_wb_xcpt,
    input  logic [2:0]           alu_wb_xcpt_type,
    input  logic [DATA_W-1:0]    alu_wb_xcpt_addr,
    input  logic                 mul_wb_valid,
    input  logic [ROB_IDX_W-1:0] mul_wb_id,
    input  logic                 mul_wb_we,
    input  logic [REG_W-1:0]     mul_wb_rd,
    input  logic [DATA_W-1:0]    mul_wb_data,
    input  logic [DATA_W-1:0]    mul_wb_pc,
    input  logic                 mul_wb_xcpt,
    input  logic [2:0]           mul_wb_xcpt_type,
    input  logic [DATA_W-1:0]    mul_wb_xcpt_addr,
    output logic                 writeEnRF,
    output logic [DATA_W-1:0]    writeValRF,
    output logic [REG_W-1:0]     destRF,
    output logic [ROB_IDX_W-1:0] write_idRF,
    output logic                 xcpt_valid,
    output logic [DATA_W-1:0]    rmPC,
    output logic [DATA_W-1:0]    rmAddr,
    output logic [2:0]           xcpt_type,
    output logic                 flush_rob,
    output logic                 rob_full,
    output logic                 rob_empty,
    output logic                 overflow_err
);

    localparam logic [ROB_IDX_W:0]   FULL_CNT = (ROB_IDX_W + 1)'(ROB_ENTRIES);
    localparam logic [ROB_IDX_W:0]   CNT_ONE  = (ROB_IDX_W + 1)'(1);
    localparam logic [ROB_IDX_W-1:0] IDX_ONE  = ROB_IDX_W'(1);

    // Entry payload; only the done bits need a reset value.
    logic [ROB_ENTRIES-1:0] r_done;
    logic                   r_we        [ROB_ENTRIES];
    logic [REG_W-1:0]       r_rd        [ROB_ENTRIES];
    logic [DATA_W-1:0]      r_data      [ROB_ENTRIES];
    logic [DATA_W-1:0]      r_pc        [ROB_ENTRIES];
    logic                   r_xcpt      [ROB_ENTRIES];
    logic [2:0]             r_xcpt_type [ROB_ENTRIES];
    logic [DATA_W-1:0]      r_xcpt_addr [ROB_ENTRIES];

    logic [ROB_IDX_W-1:0] r_head;
    logic [ROB_IDX_W:0]   r_count;

    logic                 r_write_en;
    logic [DATA_W-1:0]    r_write_val;
    logic [REG_W-1:0]     r_dest;
    logic [ROB_IDX_W-1:0] r_write_id;
    logic                 r_xcpt_valid;
    logic [DATA_W-1:0]    r_rm_pc;
    logic [DATA_W-1:0]    r_rm_addr;
    logic [2:0]           r_rm_type;
    logic                 r_flush_rob;
    logic                 r_overflow;

    logic                 w_commit;
    logic                 w_xcpt_commit;
    logic                 w_accept;
    logic                 w_alu_wr;
    logic                 w_mul_wr;
    logic                 w_collide;
    logic                 w_alloc;
    logic                 w_full;
    logic                 w_alloc_err;
    logic                 w_err;
    logic [ROB_IDX_W:0]   w_count_next;

    // Commit decision, completion acceptance, occupancy update and error detection.
    always_comb begin
        w_commit      = r_done[r_head] & ~r_flush_rob;
        w_xcpt_commit = w_commit & r_xcpt[r_head];
        // Inputs are dropped in the flush cycle and at the edge that starts the flush.
        w_accept      = ~r_flush_rob & ~w_xcpt_commit;
        w_collide     = alu_wb_valid & mul_wb_valid & (alu_wb_id == mul_wb_id);
        w_alu_wr      = w_accept & alu_wb_valid;
        w_mul_wr      = w_accept & mul_wb_valid & ~w_collide;
        w_alloc       = w_accept & alloc_valid;
        w_full        = (r_count == FULL_CNT);
        w_count_next  = r_count;
        w_alloc_err   = 1'b0;
        if (w_alloc && !w_commit) begin
            if (w_full) begin
                w_alloc_err = 1'b1;
            end else begin
                w_count_next = r_count + CNT_ONE;
            end
        end else if (!w_alloc && w_commit) begin
            w_count_next = r_count - CNT_ONE;
        end
        w_err = w_alloc_err
              | (w_alu_wr & r_done[alu_wb_id])
              | (w_accept & w_collide)
              | (w_mul_wr & r_done[mul_wb_id]);
    end

    // Capture completion payloads; on a shared id the MUL write is suppressed.
    always_ff @(posedge clock) begin
        if (w_alu_wr) begin
            r_we[alu_wb_id]        <= alu_wb_we;
            r_rd[alu_wb_id]        <= alu_wb_rd;
            r_data[alu_wb_id]      <= alu_wb_data;
            r_pc[alu_wb_id]        <= alu_wb_pc;
            r_xcpt[alu_wb_id]      <= alu_wb_xcpt;
            r_xcpt_type[alu_wb_id] <= alu_wb_xcpt_type;
            r_xcpt_addr[alu_wb_id] <= alu_wb_xcpt_addr;
        end
        if (w_mul_wr) begin
            r_we[mul_wb_id]        <= mul_wb_we;
            r_rd[mul_wb_id]        <= mul_wb_rd;
            r_data[mul_wb_id]      <= mul_wb_data;
            r_pc[mul_wb_id]        <= mul_wb_pc;
            r_xcpt[mul_wb_id]      <= mul_wb_xcpt;
            r_xcpt_type[mul_wb_id] <= mul_wb_xcpt_type;
            r_xcpt_addr[mul_wb_id] <= mul_wb_xcpt_addr;
        end
    end

    // Done bits, head/count pointers and the registered commit/exception outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done       <= '0;
            r_head       <= '0;
            r_count      <= '0;
            r_write_en   <= 1'b0;
            r_write_val  <= '0;
            r_dest       <= '0;
            r_write_id   <= '0;
            r_xcpt_valid <= 1'b0;
            r_rm_pc      <= '0;
            r_rm_addr    <= '0;
            r_rm_type    <= '0;
            r_flush_rob  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_write_en   <= 1'b0;
            r_write_val  <= '0;
            r_dest       <= '0;
            r_write_id   <= '0;
            r_xcpt_valid <= 1'b0;
            r_flush_rob  <= 1'b0;
            if (w_xcpt_commit) begin
                r_xcpt_valid <= 1'b1;
                r_flush_rob  <= 1'b1;
                r_rm_pc      <= r_pc[r_head];
                r_rm_addr    <= r_xcpt_addr[r_head];
                r_rm_type    <= r_xcpt_type[r_head];
                r_done       <= '0;
                r_head       <= '0;
                r_count      <= '0;
            end else begin
                if (w_commit) begin
                    r_done[r_head] <= 1'b0;
                    r_write_en     <= r_we[r_head];
                    r_write_val    <= r_data[r_head];
                    r_dest         <= r_rd[r_head];
                    r_write_id     <= r_head;
                    r_head         <= r_head + IDX_ONE;
                end
                // Later assignments win, so a completion landing on the head re-arms it.
                if (w_alu_wr) begin
                    r_done[alu_wb_id] <= 1'b1;
                end
                if (w_mul_wr) begin
                    r_done[mul_wb_id] <= 1'b1;
                end
                r_count <= w_count_next;
            end
            if (w_err) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign writeEnRF    = r_write_en;
    assign writeValRF   = r_write_val;
    assign destRF       = r_dest;
    assign write_idRF   = r_write_id;
    assign xcpt_valid   = r_xcpt_valid;
    assign rmPC         = r_rm_pc;
    assign rmAddr       = r_rm_addr;
    assign xcpt_type    = r_rm_type;
    assign flush_rob    = r_flush_rob;
    assign rob_full     = w_full;
    assign rob_empty    = (r_count == '0);
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: program-order queue model, per-cycle compare, directed and random stimulus.
module tb_rob_commit;

    logic        clock;
    logic        reset;
    logic        alloc_valid;
    logic        alu_wb_valid, mul_wb_valid;
    logic [2:0]  alu_wb_id, mul_wb_id;
    logic        alu_wb_we, mul_wb_we;
    logic [4:0]  alu_wb_rd, mul_wb_rd;
    logic [31:0] alu_wb_data, mul_wb_data, alu_wb_pc, mul_wb_pc;
    logic        alu_wb_xcpt, mul_wb_xcpt;
    logic [2:0]  alu_wb_xcpt_type, mul_wb_xcpt_type;
    logic [31:0] alu_wb_xcpt_addr, mul_wb_xcpt_addr;
    logic        writeEnRF;
    logic [31:0] writeValRF;
    logic [4:0]  destRF;
    logic [2:0]  write_idRF;
    logic        xcpt_valid;
    logic [31:0] rmPC, rmAddr;
    logic [2:0]  xcpt_type;
    logic        flush_rob, rob_full, rob_empty, overflow_err;

    rob_commit dut (
        .clock(clock), .reset(reset), .alloc_valid(alloc_valid),
        .alu_wb_valid(alu_wb_valid), .alu_wb_id(alu_wb_id), .alu_wb_we(alu_wb_we),
        .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data), .alu_wb_pc(alu_wb_pc),
        .alu_wb_xcpt(alu_wb_xcpt), .alu_wb_xcpt_type(alu_wb_xcpt_type),
        .alu_wb_xcpt_addr(alu_wb_xcpt_addr),
        .mul_wb_valid(mul_wb_valid), .mul_wb_id(mul_wb_id), .mul_wb_we(mul_wb_we),
        .mul_wb_rd(mul_wb_rd), .mul_wb_data(mul_wb_data), .mul_wb_pc(mul_wb_pc),
        .mul_wb_xcpt(mul_wb_xcpt), .mul_wb_xcpt_type(mul_wb_xcpt_type),
        .mul_wb_xcpt_addr(mul_wb_xcpt_addr),
        .writeEnRF(writeEnRF), .writeValRF(writeValRF), .destRF(destRF),
        .write_idRF(write_idRF), .xcpt_valid(xcpt_valid), .rmPC(rmPC), .rmAddr(rmAddr),
        .xcpt_type(xcpt_type), .flush_rob(flush_rob), .rob_full(rob_full),
        .rob_empty(rob_empty), .overflow_err(overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // Model: tickets in program order plus a table of completed results per ticket.
    typedef struct {
        bit          v;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        bit          xc;
        logic [2:0]  xt;
        logic [31:0] xa;
    } res_t;
    res_t        m_res [8];
    int unsigned m_q [$];
    int unsigned m_tail;

    // Expected outputs for the current cycle (e_) and after the next edge (n_).
    logic        e_we, e_xv, e_fl, e_ovf, e_full, e_empty;
    logic [31:0] e_val, e_pc, e_addr;
    logic [4:0]  e_dst;
    logic [2:0]  e_id, e_xt;
    logic        n_we, n_xv, n_fl, n_ovf, n_full, n_empty;
    logic [31:0] n_val, n_pc, n_addr;
    logic [4:0]  n_dst;
    logic [2:0]  n_id, n_xt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          commit, xc;
        int unsigned h;
        n_we = 0; n_val = 0; n_dst = 0; n_id = 0; n_xv = 0; n_fl = 0;
        n_pc = e_pc; n_addr = e_addr; n_xt = e_xt; n_ovf = e_ovf;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < 8; i++) m_res[i].v = 0;
            m_tail = 0;
            n_pc = 0; n_addr = 0; n_xt = 0; n_ovf = 0;
        end else begin
            commit = !e_fl && m_q.size() > 0 && m_res[m_q[0]].v;
            xc     = commit && m_res[m_q[0]].xc;
            if (xc) begin
                h = m_q[0];
                n_xv = 1; n_fl = 1;
                n_pc = m_res[h].pc; n_addr = m_res[h].xa; n_xt = m_res[h].xt;
                m_q.delete();
                for (int i = 0; i < 8; i++) m_res[i].v = 0;
                m_tail = 0;
            end else begin
                if (!e_fl) begin
                    if (alu_wb_valid && m_res[alu_wb_id].v) n_ovf = 1;
                    if (alu_wb_valid && mul_wb_valid && alu_wb_id == mul_wb_id) n_ovf = 1;
                    else if (mul_wb_valid && m_res[mul_wb_id].v) n_ovf = 1;
                    if (alloc_valid && m_q.size() == 8 && !commit) n_ovf = 1;
                end
                if (commit) begin
                    h = m_q.pop_front();
                    n_we = m_res[h].we; n_val = m_res[h].data; n_dst = m_res[h].rd;
                    n_id = h[2:0];
                    m_res[h].v = 0;
                end
                if (!e_fl) begin
                    if (mul_wb_valid && !(alu_wb_valid && alu_wb_id == mul_wb_id))
                        m_res[mul_wb_id] = '{1, mul_wb_we, mul_wb_rd, mul_wb_data, mul_wb_pc,
                                             mul_wb_xcpt, mul_wb_xcpt_type, mul_wb_xcpt_addr};
                    if (alu_wb_valid)
                        m_res[alu_wb_id] = '{1, alu_wb_we, alu_wb_rd, alu_wb_data, alu_wb_pc,
                                             alu_wb_xcpt, alu_wb_xcpt_type, alu_wb_xcpt_addr};
                    if (alloc_valid && m_q.size() < 8) begin
                        m_q.push_back(m_tail);
                        m_tail = (m_tail + 1) % 8;
                    end
                end
            end
        end
        n_full  = (m_q.size() == 8);
        n_empty = (m_q.size() == 0);
    endtask

    // One clock cycle with the currently driven inputs; inputs return to idle afterwards.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        e_we = n_we; e_val = n_val; e_dst = n_dst; e_id = n_id; e_xv = n_xv; e_fl = n_fl;
        e_pc = n_pc; e_addr = n_addr; e_xt = n_xt; e_ovf = n_ovf;
        e_full = n_full; e_empty = n_empty;
        chk_on = 1;
        alloc_valid = 0; alu_wb_valid = 0; mul_wb_valid = 0;
    endtask

    task automatic set_alu(input int unsigned id, input bit we, input logic [4:0] rd,
                           input logic [31:0] d, input logic [31:0] pc, input bit xc,
                           input logic [2:0] xt, input logic [31:0] xa);
        alu_wb_valid = 1; alu_wb_id = id[2:0]; alu_wb_we = we; alu_wb_rd = rd;
        alu_wb_data = d; alu_wb_pc = pc; alu_wb_xcpt = xc; alu_wb_xcpt_type = xt;
        alu_wb_xcpt_addr = xa;
    endtask

    task automatic set_mul(input int unsigned id, input bit we, input logic [4:0] rd,
                           input logic [31:0] d, input logic [31:0] pc, input bit xc,
                           input logic [2:0] xt, input logic [31:0] xa);
        mul_wb_valid = 1; mul_wb_id = id[2:0]; mul_wb_we = we; mul_wb_rd = rd;
        mul_wb_data = d; mul_wb_pc = pc; mul_wb_xcpt = xc; mul_wb_xcpt_type = xt;
        mul_wb_xcpt_addr = xa;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic allocs(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1;
            tick();
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            chk("writeEnRF", writeEnRF, e_we);
            chk("writeValRF", writeValRF, e_val);
            chk("destRF", destRF, e_dst);
            chk("write_idRF", write_idRF, e_id);
            chk("xcpt_valid", xcpt_valid, e_xv);
            chk("rmPC", rmPC, e_pc);
            chk("rmAddr", rmAddr, e_addr);
            chk("xcpt_type", xcpt_type, e_xt);
            chk("flush_rob", flush_rob, e_fl);
            chk("rob_full", rob_full, e_full);
            chk("rob_empty", rob_empty, e_empty);
            chk("overflow_err", overflow_err, e_ovf);
        end
    end

    int unsigned cand [$];
    int unsigned k;
    bit          hit;

    initial begin
        reset = 1; alloc_valid = 0; alu_wb_valid = 0; mul_wb_valid = 0;
        set_alu(0, 0, 0, 0, 0, 0, 0, 0); set_mul(0, 0, 0, 0, 0, 0, 0, 0);
        alu_wb_valid = 0; mul_wb_valid = 0;
        e_pc = 0; e_addr = 0; e_xt = 0; e_ovf = 0; e_fl = 0;

        // Reset state
        do_reset();
        chk("rst_empty", rob_empty, 1);
        chk("rst_we", writeEnRF, 0);
        chk("rst_ovf", overflow_err, 0);

        // Basic retire: alloc, complete, commit two edges after the completion
        allocs(1);
        set_alu(0, 1, 5, 32'h1234, 32'h40, 0, 0, 0);
        tick();
        tick();
        chk("basic_we", writeEnRF, 1);
        chk("basic_rd", destRF, 5);
        chk("basic_val", writeValRF, 32'h1234);
        chk("basic_id", write_idRF, 0);
        chk("basic_empty", rob_empty, 1);

        // Out-of-order completion, in-order retirement
        do_reset();
        allocs(3);
        set_mul(1, 1, 7, 32'h11, 32'h4, 0, 0, 0); tick();
        set_alu(2, 1, 8, 32'h22, 32'h8, 0, 0, 0); tick();
        tick();
        chk("ooo_hold", writeEnRF, 0);
        set_alu(0, 1, 9, 32'h33, 32'h0, 0, 0, 0); tick();
        tick(); chk("ooo_id0", write_idRF, 0); chk("ooo_we0", writeEnRF, 1);
        tick(); chk("ooo_id1", write_idRF, 1); chk("ooo_val1", writeValRF, 32'h11);
        tick(); chk("ooo_id2", write_idRF, 2); chk("ooo_val2", writeValRF, 32'h22);

        // Full, overflow on the ninth alloc, then head wrap
        do_reset();
        allocs(8);
        chk("full_flag", rob_full, 1);
        allocs(1);
        chk("full_ovf", overflow_err, 1);
        chk("full_hold", rob_full, 1);
        for (int i = 0; i < 8; i++) begin
            set_alu(i, 1, 5'(i + 1), 32'h100 + 32'(i), 32'(i * 4), 0, 0, 0);
            tick();
        end
        tick();
        chk("wrap_id7", write_idRF, 7);
        allocs(3);
        set_alu(0, 1, 3, 32'hA0, 32'h20, 0, 0, 0); tick();
        tick();
        chk("wrap_id0", write_idRF, 0);
        chk("wrap_we0", writeEnRF, 1);
        set_alu(1, 0, 4, 32'hA1, 32'h24, 0, 0, 0);
        set_mul(2, 1, 6, 32'hA2, 32'h28, 0, 0, 0);
        tick();
        idles(4);
        chk("wrap_empty", rob_empty, 1);

        // Exception commit flushes younger completed entries
        do_reset();
        allocs(4);
        set_alu(2, 1, 2, 32'h22, 32'h108, 0, 0, 0);
        set_mul(3, 1, 3, 32'h33, 32'h10C, 0, 0, 0);
        tick();
        set_alu(1, 1, 1, 32'h11, 32'h100, 1, 3'h2, 32'hDEAD); tick();
        set_alu(0, 1, 4, 32'h44, 32'hFC, 0, 0, 0); tick();
        tick();
        chk("xc_pre_id", write_idRF, 0);
        chk("xc_pre_we", writeEnRF, 1);
        tick();
        chk("xc_valid", xcpt_valid, 1);
        chk("xc_flush", flush_rob, 1);
        chk("xc_pc", rmPC, 32'h100);
        chk("xc_addr", rmAddr, 32'hDEAD);
        chk("xc_type", xcpt_type, 3'h2);
        chk("xc_we", writeEnRF, 0);
        chk("xc_empty", rob_empty, 1);
        tick();
        chk("xc_pulse", xcpt_valid, 0);
        chk("xc_hold_pc", rmPC, 32'h100);
        idles(5);
        chk("xc_no_commit", writeEnRF, 0);

        // Dual completion with distinct ids, then same-id collision
        do_reset();
        allocs(3);
        set_alu(0, 1, 1, 1, 0, 0, 0, 0); set_mul(1, 1, 2, 2, 4, 0, 0, 0); tick();
        set_alu(2, 0, 3, 3, 8, 0, 0, 0); tick();
        idles(4);
        allocs(3);
        set_alu(3, 1, 10, 32'h333, 32'hC, 0, 0, 0);
        set_mul(4, 1, 11, 32'h444, 32'h10, 0, 0, 0);
        tick();
        tick(); chk("dual_id3", write_idRF, 3); chk("dual_val3", writeValRF, 32'h333);
        tick(); chk("dual_id4", write_idRF, 4); chk("dual_val4", writeValRF, 32'h444);
        set_alu(5, 1, 12, 32'hAAAA, 32'h14, 0, 0, 0);
        set_mul(5, 1, 13, 32'hBBBB, 32'h14, 0, 0, 0);
        tick();
        chk("coll_ovf", overflow_err, 1);
        tick();
        chk("coll_id", write_idRF, 5);
        chk("coll_val", writeValRF, 32'hAAAA);
        chk("coll_rd", destRF, 12);

        // Reset while committing
        do_reset();
        allocs(4);
        set_alu(0, 1, 1, 32'h10, 0, 0, 0, 0); set_mul(1, 1, 2, 32'h20, 4, 0, 0, 0); tick();
        set_alu(2, 1, 3, 32'h30, 8, 0, 0, 0); set_mul(3, 1, 4, 32'h40, 12, 0, 0, 0); tick();
        do_reset();
        chk("mid_rst_we", writeEnRF, 0);
        chk("mid_rst_val", writeValRF, 0);
        chk("mid_rst_empty", rob_empty, 1);
        idles(5);
        chk("mid_rst_quiet", writeEnRF, 0);
        allocs(1);
        set_alu(0, 1, 9, 32'h99, 0, 0, 0, 0); tick();
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if (writeEnRF) hit = 1;
        end
        chk("mid_rst_resume", {31'd0, hit}, 1);
        chk("mid_rst_val2", writeValRF, 32'h99);

        // Randomized legal traffic with occasional exceptions
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            cand.delete();
            foreach (m_q[i]) if (!m_res[m_q[i]].v) cand.push_back(m_q[i]);
            if (m_q.size() < 8 && $urandom_range(0, 2) != 0) alloc_valid = 1;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                set_alu(cand[k], 1'($urandom), 5'($urandom), $urandom, $urandom,
                        ($urandom_range(0, 24) == 0), 3'($urandom), $urandom);
                cand.delete(k);
            end
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                set_mul(cand[k], 1'($urandom), 5'($urandom), $urandom, $urandom,
                        ($urandom_range(0, 24) == 0), 3'($urandom), $urandom);
            end
            tick();
        end
        idles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- 8-entry reorder buffer and commit stage downstream of the ALU and MUL pipes.
- Captures out-of-order completions, indexed by the ROB ticket decode issued.
- Retires one entry per cycle in program order.
- Drives the decode/register-file writeback port (writeEnRF, writeValRF, destRF, write_idRF) and the exception/flush interface (xcpt_valid, rmPC, rmAddr, xcpt_type, flush_rob).

Parameters:
ROB_ENTRIES, 8, number of entries; power of two
ROB_IDX_W, 3, ticket width, log2(ROB_ENTRIES)
DATA_W, 32, result and PC width
REG_W, 5, architectural register index width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_valid  in  1  decode issued one instruction this cycle (req_to_alu_valid | req_to_mul_valid)
alu_wb_valid  in  1  ALU completion
alu_wb_id  in  3  ROB ticket of ALU completion
alu_wb_we  in  1  completion writes a register
alu_wb_rd  in  5  destination register
alu_wb_data  in  32  result
alu_wb_pc  in  32  instruction PC
alu_wb_xcpt  in  1  instruction raised an exception
alu_wb_xcpt_type  in  3  exception cause
alu_wb_xcpt_addr  in  32  faulting address
mul_wb_*  in  (same set and widths as alu_wb_*)  MUL completion
writeEnRF  out  1  commit register write
writeValRF  out  32  commit data
destRF  out  5  commit destination
write_idRF  out  3  ticket of committing entry
xcpt_valid  out  1  exception committed
rmPC  out  32  PC of excepting instruction
rmAddr  out  32  faulting address
xcpt_type  out  3  cause
flush_rob  out  1  pipeline flush pulse
rob_full  out  1  occupancy == ROB_ENTRIES; decode must stall
rob_empty  out  1  occupancy == 0
overflow_err  out  1  sticky protocol-violation flag

Behaviour:
- Per-entry state: done, we, rd, data, pc, xcpt, xcpt_type, xcpt_addr. Plus head[2:0] and count[3:0].
- Reset: every done bit = 0, head = 0, count = 0. All outputs 0, except rob_empty = 1.
- Completion write: on alu_wb_valid, entry[alu_wb_id] is written and done set at the next edge; MUL likewise.
  - ALU and MUL with different ids in the same cycle: both are written.
  - ALU and MUL with the same id: ALU wins and overflow_err is set.
  - Completion to an entry whose done bit is already 1: the entry is overwritten and overflow_err is set.
- Commit condition: done[head] = 1 and no flush in progress. At most one commit per cycle.
- Commit outputs are registered: they are valid in the cycle after done[head] is observed set. Minimum completion-to-RF latency is 2 cycles (capture edge, then commit edge).
- Normal commit (xcpt = 0):
  - writeEnRF = entry.we; destRF = rd; writeValRF = data; write_idRF = head; each for one cycle.
  - done[head] is cleared; head increments modulo 8, wrapping 7 -> 0.
  - we = 0 (branch, store, nop): same retirement, writeEnRF = 0.
- Exception commit (xcpt = 1):
  - xcpt_valid = 1 and flush_rob = 1 for exactly one cycle.
  - rmPC = pc, rmAddr = xcpt_addr, xcpt_type = xcpt_type.
  - writeEnRF = 0 and the excepting entry's result is discarded.
  - At the same edge: all done bits are cleared, head = 0, count = 0. This matches decode resetting its tail to 0 on flush_rob.
  - alloc_valid and completions in the flush_rob cycle are ignored.
- rmPC, rmAddr and xcpt_type hold their last value until the next exception; reset clears them to 0.
- Occupancy:
  - count_next = count + alloc_valid - commit.
  - Allocation and commit in the same cycle leave count unchanged.
  - alloc_valid while count == 8 and no commit: count is held and overflow_err is set.
  - rob_full and rob_empty are decoded combinationally from the count register.
- overflow_err is cleared only by reset.
- Reset mid-operation discards all entries. No commit output is asserted in the cycle after reset.

Test Plan:
- Basic retire: reset; alloc id0; ALU wb id0 with we=1, rd=5, data=0x1234 -> two cycles later writeEnRF=1, destRF=5, writeValRF=0x1234, write_idRF=0, then count returns to 0.
- Out-of-order completion: alloc ids 0,1,2; MUL completes id1, ALU completes id2, then ALU completes id0 -> commits appear on consecutive cycles with write_idRF 0,1,2, and none before id0 completes.
- Full and wrap: 8 allocs without completions -> rob_full=1. A 9th alloc sets overflow_err=1 and count stays 8. Complete all 8; alloc and complete 3 more -> head wraps and the next commit after id7 has write_idRF=0.
- Exception: ids 0..3 allocated; id1 completes with xcpt=1, type=3'h2, pc=0x100, addr=0xDEAD -> id0 commits normally, then xcpt_valid=flush_rob=1 for one cycle with rmPC=0x100, rmAddr=0xDEAD, xcpt_type=2. Afterwards count=0, head=0, and the id2/id3 completions that arrived earlier never commit.
- Same-cycle dual completion: ALU id3 and MUL id4 with head=3 -> id3 commits, then id4 on the next cycle. A same-id collision on id5 -> the ALU data is committed and overflow_err=1.
- Reset mid-operation: 4 entries done and committing; assert reset for 1 cycle -> all outputs 0, rob_empty=1, no writeEnRF afterward until a new alloc and completion.
